// File: rtl/keycode_note_decoder.sv
// keycode_note_decoder
//   Turns PS/2 scan-code set 2 {prefix, make-code} words into a held-note map
//   and presents it as a compacted, pitch-ascending note list plus a count.
//   Note byte: {octave[7:4], semitone[3:0]}, semitone 1=C .. 12=B, 0x00 = none.
//   Optional macro OCTAVE_SHIFT_EN: z/x (0x1A/0x22) shift the base octave
//   within 1..7 while no notes are held. Without it the base octave is fixed at 4.
module keycode_note_decoder #(
   parameter int MAX_NOTES = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [15:0]                keycode,
   output logic [MAX_NOTES-1:0][7:0]  notes,
   output logic [4:0]                 note_num
);

   localparam int         NUM_PITCH   = 108;            // 9 octaves x 12 semitones
   localparam logic [7:0] PFX_PRESS   = 8'h00;
   localparam logic [7:0] PFX_RELEASE = 8'hF0;
   localparam logic [6:0] MAX_CNT     = 7'(MAX_NOTES);

   // Make code -> {mapped, semitone offset from base C}
   function automatic logic [5:0] key_offset(input logic [7:0] code);
      case (code)
         8'h1C:   key_offset = {1'b1, 5'd0};
         8'h1D:   key_offset = {1'b1, 5'd1};
         8'h1B:   key_offset = {1'b1, 5'd2};
         8'h24:   key_offset = {1'b1, 5'd3};
         8'h23:   key_offset = {1'b1, 5'd4};
         8'h2B:   key_offset = {1'b1, 5'd5};
         8'h2C:   key_offset = {1'b1, 5'd6};
         8'h34:   key_offset = {1'b1, 5'd7};
         8'h35:   key_offset = {1'b1, 5'd8};
         8'h33:   key_offset = {1'b1, 5'd9};
         8'h3C:   key_offset = {1'b1, 5'd10};
         8'h3B:   key_offset = {1'b1, 5'd11};
         8'h42:   key_offset = {1'b1, 5'd12};
         8'h44:   key_offset = {1'b1, 5'd13};
         8'h4B:   key_offset = {1'b1, 5'd14};
         8'h4D:   key_offset = {1'b1, 5'd15};
         8'h4C:   key_offset = {1'b1, 5'd16};
         default: key_offset = 6'd0;
      endcase
   endfunction

   logic [15:0]          last_kc;
   logic [NUM_PITCH-1:0] note_map;   // bit p = octave p/12, semitone p%12+1
   logic [3:0]           base_oct;

   logic                 kc_event;
   logic [5:0]           key_dec;
   logic                 key_hit;
   logic [4:0]           key_off;
   logic                 key_wrap;
   logic [3:0]           note_oct;
   logic [3:0]           note_semi;
   logic [6:0]           pitch_idx;
   logic [NUM_PITCH-1:0] pitch_bit;

   // An unknown keycode makes the inequality unknown, which the event logic
   // treats as "no event", so X on the bus before the first word is harmless.
   assign kc_event  = start && (keycode != last_kc);
   assign key_dec   = key_offset(keycode[7:0]);
   assign key_hit   = key_dec[5];
   assign key_off   = key_dec[4:0];
   assign key_wrap  = (key_off >= 5'd12);
   assign note_oct  = base_oct + {3'b000, key_wrap};
   assign note_semi = key_wrap ? 4'(key_off - 5'd12) : key_off[3:0];
   assign pitch_idx = 7'(note_oct) * 7'd12 + 7'(note_semi);
   assign pitch_bit = {{(NUM_PITCH-1){1'b0}}, 1'b1} << pitch_idx;

   // ---- stage 0: event detection and held-note map update ----
   // Apply one press/release per keycode change; reset wins over an event.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_kc  <= '0;
         note_map <= '0;
      end else if (kc_event) begin
         last_kc <= keycode;
         if (key_hit && keycode[15:8] == PFX_PRESS)
            note_map <= note_map | pitch_bit;
         else if (key_hit && keycode[15:8] == PFX_RELEASE)
            note_map <= note_map & ~pitch_bit;
      end
   end

`ifdef OCTAVE_SHIFT_EN
   // Base octave moves only on a z/x press while nothing is held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         base_oct <= 4'd4;
      end else if (kc_event && note_map == '0) begin
         if (keycode == 16'h001A && base_oct > 4'd1)
            base_oct <= base_oct - 4'd1;
         else if (keycode == 16'h0022 && base_oct < 4'd7)
            base_oct <= base_oct + 4'd1;
      end
   end
`else
   assign base_oct = 4'd4;
`endif

   logic [MAX_NOTES-1:0][7:0] list_nx;
   logic [6:0]                held_cnt;
   logic [4:0]                num_nx;

   // Walk from highest to lowest pitch, pushing each held note into slot 0;
   // overflow falls off the top, leaving the lowest MAX_NOTES in order.
   always_comb begin
      list_nx  = '0;
      held_cnt = '0;
      for (int p = NUM_PITCH - 1; p >= 0; p--) begin
         if (note_map[p]) begin
            for (int k = MAX_NOTES - 1; k > 0; k--)
               list_nx[k] = list_nx[k-1];
            list_nx[0] = {4'(p / 12), 4'((p % 12) + 1)};
            held_cnt   = held_cnt + 7'd1;
         end
      end
   end

   assign num_nx = (held_cnt > MAX_CNT) ? MAX_CNT[4:0] : held_cnt[4:0];

   // ---- stage 1: registered note list and count ----
   // Output registers follow the map one edge later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         notes    <= '0;
         note_num <= '0;
      end else begin
         notes    <= list_nx;
         note_num <= num_nx;
      end
   end

endmodule

// File: tb/tb_keycode_note_decoder.sv
// Testbench for keycode_note_decoder: directed scenarios followed by random
// key traffic, all checked each cycle against a behavioural note model.
module tb_keycode_note_decoder;

   localparam int MAX_NOTES = 8;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic                      start = 1'b0;
   logic [15:0]               keycode = 16'h0000;
   logic [MAX_NOTES-1:0][7:0] notes;
   logic [4:0]                note_num;

   keycode_note_decoder #(.MAX_NOTES(MAX_NOTES)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .keycode  (keycode),
      .notes    (notes),
      .note_num (note_num)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_held [0:8][1:12];
   logic [15:0] m_last;
   int          m_base;
   logic [7:0]  exp_notes [MAX_NOTES];
   int          exp_num;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int key_semitones(input logic [7:0] c);
      case (c)
         8'h1C: return 0;   8'h1D: return 1;   8'h1B: return 2;
         8'h24: return 3;   8'h23: return 4;   8'h2B: return 5;
         8'h2C: return 6;   8'h34: return 7;   8'h35: return 8;
         8'h33: return 9;   8'h3C: return 10;  8'h3B: return 11;
         8'h42: return 12;  8'h44: return 13;  8'h4B: return 14;
         8'h4D: return 15;  8'h4C: return 16;
         default: return -1;
      endcase
   endfunction

   function automatic bit any_held();
      for (int o = 0; o <= 8; o++)
         for (int s = 1; s <= 12; s++)
            if (m_held[o][s]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int o = 0; o <= 8; o++)
         for (int s = 1; s <= 12; s++)
            m_held[o][s] = 1'b0;
      m_last = 16'h0000;
      m_base = 4;
   endtask

   // Held notes in ascending pitch order, truncated to the list length.
   task automatic model_outputs();
      logic [7:0] q[$];
      for (int o = 0; o <= 8; o++)
         for (int s = 1; s <= 12; s++)
            if (m_held[o][s]) q.push_back({4'(o), 4'(s)});
      exp_num = (q.size() > MAX_NOTES) ? MAX_NOTES : q.size();
      for (int k = 0; k < MAX_NOTES; k++)
         exp_notes[k] = (k < q.size()) ? q[k] : 8'h00;
   endtask

   task automatic model_event(input logic [15:0] kc);
      int off;
      int oct;
      int semi;
      off = key_semitones(kc[7:0]);
      if (off >= 0) begin
         oct  = m_base + off / 12;
         semi = off % 12 + 1;
         if (kc[15:8] == 8'h00) m_held[oct][semi] = 1'b1;
         else if (kc[15:8] == 8'hF0) m_held[oct][semi] = 1'b0;
      end
`ifdef OCTAVE_SHIFT_EN
      if (!any_held()) begin
         if (kc == 16'h001A && m_base > 1) m_base = m_base - 1;
         if (kc == 16'h0022 && m_base < 7) m_base = m_base + 1;
      end
`endif
   endtask

   // One clock: drive on the falling edge, advance the model on the rising
   // edge (outputs reflect the map as it stood before this edge), compare after.
   task automatic step(input logic r, input logic s, input logic [15:0] kc);
      @(negedge clk);
      reset   = r;
      start   = s;
      keycode = kc;
      @(posedge clk);
      if (!r) begin
         model_clear();
         exp_num = 0;
         for (int k = 0; k < MAX_NOTES; k++) exp_notes[k] = 8'h00;
      end else begin
         model_outputs();
         if (s && kc != m_last) begin
            m_last = kc;
            model_event(kc);
         end
      end
      #1;
      check("note_num", 32'(note_num), 32'(exp_num));
      for (int k = 0; k < MAX_NOTES; k++)
         check($sformatf("notes[%0d]", k), 32'(notes[k]), 32'(exp_notes[k]));
   endtask

   logic [7:0] code_pool [20] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44,
                                 8'h4B, 8'h4D, 8'h4C, 8'h15, 8'h1A, 8'h22};
   logic [7:0] scale9 [9] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35};

   initial begin
      logic [15:0] kc;
      logic        r;
      logic        s;
      int          sel;

      model_clear();

      // Reset held for five cycles
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0000);
      check("reset_num", 32'(note_num), 32'd0);
      check("reset_notes", 32'(notes[0]), 32'h00);

      // Single press / release of a
      repeat (2) step(1'b1, 1'b1, 16'h001C);
      check("a_note0", 32'(notes[0]), 32'h41);
      check("a_num", 32'(note_num), 32'd1);
      repeat (2) step(1'b1, 1'b1, 16'hF01C);
      check("a_rel_num", 32'(note_num), 32'd0);

      // w
      repeat (2) step(1'b1, 1'b1, 16'h001D);
      check("w_note0", 32'(notes[0]), 32'h42);
      repeat (2) step(1'b1, 1'b1, 16'hF01D);
      check("w_rel_num", 32'(note_num), 32'd0);

      // Chord s + e
      step(1'b1, 1'b1, 16'h001B);
      repeat (2) step(1'b1, 1'b1, 16'h0024);
      check("chord_n0", 32'(notes[0]), 32'h43);
      check("chord_n1", 32'(notes[1]), 32'h44);
      check("chord_num", 32'(note_num), 32'd2);
      repeat (2) step(1'b1, 1'b1, 16'hF01B);
      check("chord_rel_n0", 32'(notes[0]), 32'h44);
      repeat (2) step(1'b1, 1'b1, 16'hF024);

      // Overflow: nine keys held
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, {8'h00, scale9[i]});
      step(1'b1, 1'b1, {8'h00, scale9[8]});
      check("ovf_num", 32'(note_num), 32'd8);
      check("ovf_n7", 32'(notes[7]), 32'h48);
      repeat (2) step(1'b1, 1'b1, 16'hF01C);
      check("ovf_rel_n0", 32'(notes[0]), 32'h42);
      check("ovf_rel_n7", 32'(notes[7]), 32'h49);
      check("ovf_rel_num", 32'(note_num), 32'd8);
      for (int i = 1; i < 9; i++) step(1'b1, 1'b1, {8'hF0, scale9[i]});
      step(1'b1, 1'b1, 16'hF035);

      // Gating and mid-hold reset
      repeat (3) step(1'b1, 1'b0, 16'h001C);
      check("gate_num", 32'(note_num), 32'd0);
      repeat (2) step(1'b1, 1'b1, 16'h001C);
      check("gate_open_n0", 32'(notes[0]), 32'h41);
      step(1'b0, 1'b1, 16'h001C);
      check("midrst_num", 32'(note_num), 32'd0);
      repeat (2) step(1'b1, 1'b1, 16'h001C);
      repeat (2) step(1'b1, 1'b1, 16'hF01C);

      // Invalid prefix / unmapped code
      repeat (2) step(1'b1, 1'b1, 16'hE01C);
      check("e0_num", 32'(note_num), 32'd0);
      repeat (2) step(1'b1, 1'b1, 16'h0015);
      check("unmapped_num", 32'(note_num), 32'd0);
`ifdef OCTAVE_SHIFT_EN
      repeat (2) step(1'b1, 1'b1, 16'h0022);
      repeat (2) step(1'b1, 1'b1, 16'h001C);
      check("shift_n0", 32'(notes[0]), 32'h51);
      repeat (2) step(1'b1, 1'b1, 16'hF01C);
`endif

      // Random traffic
      kc = 16'h0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) != 0) begin
            sel = int'($urandom_range(0, 9));
            kc[15:8] = (sel < 5) ? 8'h00 : (sel < 9) ? 8'hF0 : 8'hE0;
            kc[7:0]  = code_pool[$urandom_range(0, 19)];
         end
         r = ($urandom_range(0, 149) != 0);
         s = ($urandom_range(0, 9) != 0);
         step(r, s, kc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
